// File: rtl/proc_dma_pkg.sv
// Shared types for the proc_dma word-copy engine and for other data-memory initiators.
// Fill support in the engine is compiled in with the PROC_DMA_FILL_EN macro.
package proc_dma_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic MEMREQ_READ  = 1'b0;
  localparam logic MEMREQ_WRITE = 1'b1;

endpackage

// File: rtl/proc_dma_ctrl.sv
// Sequencing FSM for proc_dma: handshake, status outputs and request valid/type.
// With PROC_DMA_FILL_EN defined, a fill transfer loops in WRITE and never visits READ.
module proc_dma_ctrl
  import proc_dma_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic start_val,
  input  logic len_zero,
  input  logic last,
  input  logic fill_mode,
  output logic start_rdy,
  output logic busy,
  output logic done,
  output logic req_val,
  output logic req_type
);

  state_t state_reg;
  state_t state_next;

`ifdef PROC_DMA_FILL_EN
  logic fill_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_reg <= 1'b0;
    end else if (start_val && state_reg == IDLE) begin
      fill_reg <= fill_mode;
    end
  end
`else
  logic unused_fill_mode;
  assign unused_fill_mode = fill_mode;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start_val) begin
          if (len_zero) begin
            state_next = DONE;
          end else begin
`ifdef PROC_DMA_FILL_EN
            state_next = fill_mode ? WRITE : READ;
`else
            state_next = READ;
`endif
          end
        end
      end
      READ:  state_next = WRITE;
      WRITE: begin
        if (last) begin
          state_next = DONE;
        end else begin
`ifdef PROC_DMA_FILL_EN
          state_next = fill_reg ? WRITE : READ;
`else
          state_next = READ;
`endif
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    start_rdy = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    req_val   = 1'b0;
    req_type  = MEMREQ_READ;
    case (state_reg)
      IDLE: begin
        start_rdy = 1'b1;
        busy      = 1'b0;
      end
      READ: begin
        req_val  = 1'b1;
        req_type = MEMREQ_READ;
      end
      WRITE: begin
        req_val  = 1'b1;
        req_type = MEMREQ_WRITE;
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
        start_rdy = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/proc_dma.sv
// Single-channel word-copy DMA initiator: pointers, word counter and data register.
// Optional fill mode is compiled in with the PROC_DMA_FILL_EN macro.
module proc_dma
  import proc_dma_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_val,
  output logic             start_rdy,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len,
  input  logic             fill_mode,
  input  logic [31:0]      fill_data,
  output logic             busy,
  output logic             done,
  output logic             dmemreq_val,
  output logic             dmemreq_type,
  output logic [31:0]      dmemreq_addr,
  output logic [31:0]      dmemreq_wdata,
  input  logic [31:0]      dmemresp_rdata
);

  logic [31:0]      src_reg;
  logic [31:0]      dst_reg;
  logic [31:0]      data_reg;
  logic [LEN_W-1:0] remaining_reg;
  logic             accept;
  logic             req_val;
  logic             req_type;
  logic             is_read;
  logic             is_write;

  assign accept   = start_val && start_rdy;
  assign is_read  = req_val && (req_type == MEMREQ_READ);
  assign is_write = req_val && (req_type == MEMREQ_WRITE);

  proc_dma_ctrl u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .start_val (start_val),
    .len_zero  (len == '0),
    .last      (remaining_reg == LEN_W'(1)),
    .fill_mode (fill_mode),
    .start_rdy (start_rdy),
    .busy      (busy),
    .done      (done),
    .req_val   (req_val),
    .req_type  (req_type)
  );

`ifndef PROC_DMA_FILL_EN
  logic unused_fill_data;
  assign unused_fill_data = ^fill_data;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_reg       <= '0;
      dst_reg       <= '0;
      data_reg      <= '0;
      remaining_reg <= '0;
    end else begin
      if (accept) begin
        src_reg       <= {src_addr[31:2], 2'b00};
        dst_reg       <= {dst_addr[31:2], 2'b00};
        remaining_reg <= len;
`ifdef PROC_DMA_FILL_EN
        // A copy overwrites this in READ, so preloading it is harmless.
        data_reg      <= fill_data;
`endif
      end
      if (is_read) begin
        data_reg <= dmemresp_rdata;
        src_reg  <= src_reg + 32'd4;
      end
      if (is_write) begin
        dst_reg       <= dst_reg + 32'd4;
        remaining_reg <= remaining_reg - LEN_W'(1);
      end
    end
  end

  assign dmemreq_val  = req_val;
  assign dmemreq_type = req_type;

  // Request fields are forced to zero whenever no request is valid.
  always_comb begin
    dmemreq_addr  = '0;
    dmemreq_wdata = '0;
    if (is_read) begin
      dmemreq_addr = src_reg;
    end else if (is_write) begin
      dmemreq_addr  = dst_reg;
      dmemreq_wdata = data_reg;
    end
  end

endmodule
